// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the channel multiplexer family.
// Mode encodings and the packet-lock FSM state type.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {SCAN, LOCK} lock_state_t;

endpackage

// File: rtl/chan_mux_rr_rr_pick.sv
// rr_pick: first valid channel scanning cyclically from ptr (ptr assumed < N).
// Latency: combinational.
// Backpressure: none; pure function of valid and ptr.
module rr_pick #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap against N so non-power-of-two N scans correctly.
            j = {1'b0, ptr} + (SELW+1)'(k);
            if (j >= (SELW+1)'(N)) j = j - (SELW+1)'(N);
            if (!found && valid[j[SELW-1:0]]) begin
                found = 1'b1;
                idx   = j[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N:1 valid/ready channel mux, fixed-select or round-robin; CHAN_MUX_PKT_LOCK_EN adds packet lock.
// Latency: 1 cycle from input transfer to out_valid (registered output, full throughput).
// Backpressure: while out_valid && !out_ready the beat holds and every in_ready is 0.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
`ifdef CHAN_MUX_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic            load_en;
    logic [SELW-1:0] ptr;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            c_ok;
    logic [SELW-1:0] c;
    logic            xfer;

    assign load_en = !out_valid || out_ready;

    rr_pick #(.N(N)) u_pick (
        .valid (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

`ifdef CHAN_MUX_PKT_LOCK_EN
    lock_state_t     state_q, state_d;
    logic [SELW-1:0] lock_ch, lock_ch_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            lock_ch <= '0;
        end else begin
            state_q <= state_d;
            lock_ch <= lock_ch_d;
        end
    end

    // c equals lock_ch whenever LOCK, so in_last[c] is the locked channel's last.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch;
        if (mode == MODE_FIXED) begin
            state_d   = SCAN;
            lock_ch_d = '0;
        end else if (xfer) begin
            if (state_q == SCAN && !in_last[c]) begin
                state_d   = LOCK;
                lock_ch_d = c;
            end else if (state_q == LOCK && in_last[c]) begin
                state_d = SCAN;
            end
        end
    end
`endif

    always_comb begin
        c_ok = 1'b0;
        c    = '0;
        if (mode == MODE_FIXED) begin
            c_ok = ({1'b0, sel} < (SELW+1)'(N));
            c    = sel;
`ifdef CHAN_MUX_PKT_LOCK_EN
        end else if (state_q == LOCK) begin
            c_ok = 1'b1;
            c    = lock_ch;
`endif
        end else begin
            c_ok = rr_found;
            c    = rr_idx;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rdy
        assign in_ready[i] = !rst && load_en && c_ok && (c == SELW'(i));
    end

    assign xfer = load_en && c_ok && in_valid[c];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= in_data[c*WIDTH +: WIDTH];
                    out_chan <= c;
                end
            end
            if (xfer && mode == MODE_RR) begin
                ptr <= (c == SELW'(N-1)) ? '0 : c + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: vector table plus reset, N=3 and packet-lock sequences.
module tb_chan_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  in_last;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [2:0]  in_last3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    always #5 clk = ~clk;

    chan_mux_rr #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef CHAN_MUX_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    chan_mux_rr #(.N(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
`ifdef CHAN_MUX_PKT_LOCK_EN
        .in_last   (in_last3),
`endif
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_chan;
    } vec_t;

    vec_t vecs[22];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        // Table: channel i data is A0+i, so expected data follows from expected channel.
        // Fixed mode, sel stepped 0..3
        vecs[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
        // Round-robin, all valid, ptr starts at 0 (fixed transfers left it alone)
        vecs[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        // Only ch1/ch3 valid, ptr=2: 3,1,3,1 exercising the 3->0 wrap
        vecs[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[13] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1};
        // Backpressure 3 cycles on the ch1 beat, then release picks ch2 (ptr=2)
        vecs[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[15] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[17] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        // No valid in RR: no ready, beat drains
        vecs[18] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
        // Fixed mode grants ready without valid; nothing captured
        vecs[19] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0001, 1'b0, 2'd0};
        // Empty register loads even with out_ready=0 (ptr=3 wraps to ch0)
        vecs[20] = '{1'b1, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[21] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};

        rst = 1'b1;
        mode = 1'b0; sel = 2'd0; in_valid = '0; out_ready = 1'b1; in_last = '0;
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; out_ready3 = 1'b1; in_last3 = '0;
        in_data3 = {8'hC2, 8'hC1, 8'hC0};

        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset out_chan",  32'(out_chan),  32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd0);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 22; v++) begin
            @(negedge clk);
            mode = vecs[v].mode; sel = vecs[v].sel;
            in_valid = vecs[v].valid; out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            if (vecs[v].exp_ov) begin
                chk($sformatf("v%0d out_chan", v), 32'(out_chan), 32'(vecs[v].exp_chan));
                chk($sformatf("v%0d out_data", v), 32'(out_data), 32'(8'hA0 + 8'(vecs[v].exp_chan)));
            end
        end

        // Async reset mid-cycle with a beat held and ptr=2
        @(negedge clk);
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pre-reset out_chan", 32'(out_chan), 32'd1);
        in_valid = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data",  32'(out_data),  32'd0);
        chk("async in_ready",  32'(in_ready),  32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("post-reset out_chan", 32'(out_chan), 32'd0);
        chk("post-reset out_valid", 32'(out_valid), 32'd1);

        // N=3 build: sel=3 selects nothing, sel=2 selects the last channel
        @(negedge clk);
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        chk("n3 sel3 in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        chk("n3 sel3 out_valid", 32'(out_valid3), 32'd0);
        @(negedge clk) sel3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #1;
        chk("n3 sel2 out_data", 32'(out_data3), 32'hC2);

`ifdef CHAN_MUX_PKT_LOCK_EN
        // ch0 sends a 3-beat packet while ch1 waits: 0,0,0 then 1
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            in_last = (b == 2) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
            chk($sformatf("lock beat%0d out_chan", b), 32'(out_chan), (b < 3) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
